// File: rtl/des_stream_pkg.sv
// Shared types and sizes for the DES byte-stream adapter.
// Block geometry and the controller state encoding live here.
package des_stream_pkg;

  localparam int BLOCK_BYTES = 8;
  localparam int BYTE_W      = 8;
  localparam int BLOCK_W     = 64;
  localparam int CNT_W       = $clog2(BLOCK_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    START,
    RELEASE
  } ctrl_state_t;

endpackage

// File: rtl/des_byte_packer.sv
// Packs an 8-bit valid/ready stream into a 64-bit block, first byte in the MSB.
// Holds the full block until the controller clears it on launch.
module des_byte_packer
  import des_stream_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [BYTE_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               clear,
  output logic [BLOCK_W-1:0] block,
  output logic               full,
  output logic [CNT_W-1:0]   count
);

  logic accept;

  assign in_ready = !full;
  assign accept   = in_valid && !full;

  // NOTE: every register here uses <= so the update order inside the block cannot change the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      block <= '0;
      full  <= 1'b0;
      count <= '0;
    end else if (clear) begin
      full  <= 1'b0;
      count <= '0;
    end else if (accept) begin
      block <= {block[BLOCK_W-BYTE_W-1:0], in_data};
      count <= count + 1'b1;
      if (count == CNT_W'(BLOCK_BYTES - 1)) full <= 1'b1;
    end
  end

endmodule

// File: rtl/des_stream_adapter.sv
// Byte-stream front end for the DES core: pack, run start/done handshake, unpack.
// Packing of the next block overlaps the drain of the current output block.
module des_stream_adapter
  import des_stream_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BLOCK_W-1:0] key_i,
  input  logic [BYTE_W-1:0]  in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [BYTE_W-1:0]  out_data_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               core_start_o,
  output logic [BLOCK_W-1:0] core_plaintext_o,
  output logic [BLOCK_W-1:0] core_key_o,
  input  logic [BLOCK_W-1:0] core_ciphertext_i,
  input  logic               core_done_i,
  output logic               busy_o,
  output logic               error_o
);

  ctrl_state_t        state;
  logic [15:0]        timer;
  logic [BLOCK_W-1:0] pk_block;
  logic               pk_full;
  logic [CNT_W-1:0]   pk_count;
  logic [BLOCK_W-1:0] ob_buf;
  logic               ob_full;
  logic [CNT_W-1:0]   ob_idx;
  logic               launch;
  logic               capture;
  logic               out_xfer;

  // A stale done from the previous transaction must be seen low before relaunching.
  assign launch   = (state == IDLE) && pk_full && !ob_full && !core_done_i;
  assign capture  = (state == START) && core_done_i;
  assign out_xfer = ob_full && out_ready_i;

  des_byte_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data_i),
    .in_valid (in_valid_i),
    .in_ready (in_ready_o),
    .clear    (launch),
    .block    (pk_block),
    .full     (pk_full),
    .count    (pk_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      timer            <= '0;
      core_start_o     <= 1'b0;
      core_plaintext_o <= '0;
      core_key_o       <= '0;
      error_o          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            core_plaintext_o <= pk_block;
            core_key_o       <= key_i;
            core_start_o     <= 1'b1;
            timer            <= '0;
            state            <= START;
          end
        end
        START: begin
          if (core_done_i) begin
            core_start_o <= 1'b0;
            state        <= RELEASE;
          end else if (timer == 16'(TIMEOUT - 1)) begin
            error_o      <= 1'b1;
            core_start_o <= 1'b0;
            state        <= RELEASE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RELEASE: begin
          if (!core_done_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output buffer shifts left so the current byte is always in the top lane.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ob_buf  <= '0;
      ob_full <= 1'b0;
      ob_idx  <= '0;
    end else if (capture) begin
      ob_buf  <= core_ciphertext_i;
      ob_full <= 1'b1;
      ob_idx  <= '0;
    end else if (out_xfer) begin
      ob_buf <= {ob_buf[BLOCK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
      ob_idx <= ob_idx + 1'b1;
      if (ob_idx == CNT_W'(BLOCK_BYTES - 1)) ob_full <= 1'b0;
    end
  end

  assign out_data_o  = ob_buf[BLOCK_W-1 -: BYTE_W];
  assign out_valid_o = ob_full;
  assign busy_o      = (pk_count != '0) | pk_full | ob_full | (state != IDLE);

endmodule

// File: tb/tb_des_stream_adapter.sv
// Self-checking bench for des_stream_adapter with a stub XOR core and a
// queue-based reference model of the byte stream.
module tb_des_stream_adapter;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] key_i;
  logic [7:0]  in_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [7:0]  out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        core_start_o;
  logic [63:0] core_plaintext_o;
  logic [63:0] core_key_o;
  logic [63:0] core_ciphertext_i;
  logic        core_done_i;
  logic        busy_o;
  logic        error_o;

  des_stream_adapter #(.TIMEOUT(64)) dut (
    .clk               (clk),
    .reset             (reset),
    .key_i             (key_i),
    .in_data_i         (in_data_i),
    .in_valid_i        (in_valid_i),
    .in_ready_o        (in_ready_o),
    .out_data_o        (out_data_o),
    .out_valid_o       (out_valid_o),
    .out_ready_i       (out_ready_i),
    .core_start_o      (core_start_o),
    .core_plaintext_o  (core_plaintext_o),
    .core_key_o        (core_key_o),
    .core_ciphertext_i (core_ciphertext_i),
    .core_done_i       (core_done_i),
    .busy_o            (busy_o),
    .error_o           (error_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stub core configuration
  int core_lat  = 18;
  bit core_never = 1'b0;
  int done_hold = 0;
  int stub_cnt  = 0;

  // Reference model state
  logic [63:0] acc;
  int          nacc;
  logic [63:0] blk_q[$];
  logic [7:0]  exp_q[$];
  logic [63:0] pend_ct, pend_key, key_prev, last_word, blk;
  logic        start_prev, done_prev;
  int pulses = 0, done_viol = 0, timeouts = 0, nout = 0;
  int start_len = 0, start_len_last = 0, low_cnt = 0, last_gap = 0;
  bit overlap_seen = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  64'(in_ready_o),       64'd1);
    check({tag, "_out_valid"}, 64'(out_valid_o),      64'd0);
    check({tag, "_out_data"},  64'(out_data_o),       64'd0);
    check({tag, "_start"},     64'(core_start_o),     64'd0);
    check({tag, "_pt"},        core_plaintext_o,      64'd0);
    check({tag, "_key"},       core_key_o,            64'd0);
    check({tag, "_busy"},      64'(busy_o),           64'd0);
    check({tag, "_error"},     64'(error_o),          64'd0);
  endtask

  // Called on a falling edge; returns on the falling edge after the byte is taken.
  task automatic send_byte(input logic [7:0] b);
    bit taken;
    int n;
    taken = 1'b0;
    n = 0;
    in_data_i  = b;
    in_valid_i = 1'b1;
    while (!taken && n < 2000) begin
      #4;
      taken = in_ready_o;
      @(negedge clk);
      n++;
    end
    in_valid_i = 1'b0;
    if (!taken) check("send_byte_bound", 64'(taken), 64'd1);
  endtask

  task automatic send_block();
    for (int i = 0; i < 8; i++) send_byte(8'($urandom));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy_o || core_done_i || core_start_o) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(n >= 3000), 64'd0);
    @(negedge clk);
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (!core_start_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(core_start_o), 64'd1);
  endtask

  // Stub core: done after core_lat start-high cycles, ciphertext = plaintext ^ key.
  initial begin
    core_done_i       = 1'b0;
    core_ciphertext_i = '0;
    forever begin
      @(negedge clk);
      if (core_start_o && !core_done_i && !core_never) begin
        stub_cnt++;
        if (stub_cnt >= core_lat) begin
          core_ciphertext_i = core_plaintext_o ^ core_key_o;
          core_done_i = 1'b1;
          stub_cnt = 0;
          for (int i = 0; i < 100 && core_start_o; i++) @(negedge clk);
          repeat (done_hold) @(negedge clk);
          core_done_i = 1'b0;
        end
      end else begin
        stub_cnt = 0;
      end
    end
  end

  // Model/monitor: samples 1 ns before each rising edge.
  initial begin
    acc = '0; nacc = 0; start_prev = 1'b0; done_prev = 1'b0;
    key_prev = '0; last_word = '0; pend_ct = '0; pend_key = '0;
    forever begin
      @(negedge clk);
      #4;
      if (reset) begin
        acc = '0; nacc = 0;
        blk_q.delete();
        exp_q.delete();
        start_prev = 1'b0; done_prev = 1'b0; start_len = 0;
        key_prev = key_i;
      end else begin
        if (in_valid_i && in_ready_o) begin
          acc = {acc[55:0], in_data_i};
          nacc++;
          if (out_valid_o) overlap_seen = 1'b1;
          if (nacc == 8) begin
            blk_q.push_back(acc);
            nacc = 0;
          end
        end
        if (core_start_o && !start_prev) begin
          pulses++;
          if (done_prev) done_viol++;
          last_gap = low_cnt;
          if (blk_q.size() == 0) begin
            check("launch_without_block", 64'(blk_q.size()), 64'd1);
          end else begin
            blk = blk_q.pop_front();
            check("launch_plaintext", core_plaintext_o, blk);
            check("launch_key", core_key_o, key_prev);
            pend_ct  = blk ^ key_prev;
            pend_key = key_prev;
          end
        end
        if (!core_start_o && start_prev) begin
          start_len_last = start_len;
          if (done_prev) begin
            check("key_held", core_key_o, pend_key);
            for (int i = 7; i >= 0; i--) exp_q.push_back(pend_ct[i*8 +: 8]);
          end else begin
            timeouts++;
          end
        end
        start_len = core_start_o ? start_len + 1 : 0;
        if (out_valid_o && out_ready_i) begin
          nout++;
          last_word = {last_word[55:0], out_data_o};
          if (exp_q.size() == 0) check("unexpected_out_byte", 64'(exp_q.size()), 64'd1);
          else check("out_byte", 64'(out_data_o), 64'(exp_q.pop_front()));
        end
        low_cnt    = core_done_i ? 0 : low_cnt + 1;
        start_prev = core_start_o;
        done_prev  = core_done_i;
        key_prev   = key_i;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  int p0, n0;

  initial begin
    reset = 1'b1; key_i = '0; in_data_i = '0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    // Known vector
    key_i = 64'h1334_5779_9BBC_DFF1;
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    wait_start("vec_start");
    check("vec_plaintext", core_plaintext_o, 64'h0102_0304_0506_0708);
    check("vec_key", core_key_o, 64'h1334_5779_9BBC_DFF1);
    wait_idle("vec_idle");
    check("vec_cipher_bytes", last_word, 64'h1236_547D_9EBA_D8F9);

    // Continuous 3-block stream with a key that keeps changing
    core_lat = 4;
    overlap_seen = 1'b0;
    p0 = pulses;
    for (int i = 0; i < 24; i++) begin
      key_i = {$urandom, $urandom};
      send_byte(8'($urandom));
    end
    wait_idle("stream_idle");
    check("stream_pulses", 64'(pulses - p0), 64'd3);
    check("stream_overlap", 64'(overlap_seen), 64'd1);
    check("stream_done_low_at_start", 64'(done_viol), 64'd0);

    // Back-pressure
    out_ready_i = 1'b0;
    p0 = pulses;
    key_i = {$urandom, $urandom};
    send_block();
    for (int n = 0; n < 200 && !out_valid_o; n++) @(negedge clk);
    check("bp_first_captured", 64'(out_valid_o), 64'd1);
    send_block();
    repeat (30) @(negedge clk);
    check("bp_in_ready", 64'(in_ready_o), 64'd0);
    check("bp_no_launch", 64'(pulses - p0), 64'd1);
    check("bp_start_low", 64'(core_start_o), 64'd0);
    out_ready_i = 1'b1;
    wait_idle("bp_idle");
    check("bp_pulses", 64'(pulses - p0), 64'd2);

    // Core timeout
    core_never = 1'b1;
    n0 = nout;
    p0 = timeouts;
    send_block();
    wait_idle("to_idle");
    check("to_start_len", 64'(start_len_last), 64'd64);
    check("to_error", 64'(error_o), 64'd1);
    check("to_count", 64'(timeouts - p0), 64'd1);
    check("to_no_output", 64'(nout - n0), 64'd0);
    core_never = 1'b0;
    core_lat = 18;
    send_block();
    wait_idle("to_next_idle");
    check("to_error_sticky", 64'(error_o), 64'd1);
    check("to_next_output", 64'(nout - n0), 64'd8);

    // Reset after a partial block
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    reset = 1'b1;
    #1;
    check_reset_vals("rst_partial");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n0 = nout;
    send_block();
    wait_idle("rst_partial_idle");
    check("rst_partial_output", 64'(nout - n0), 64'd8);

    // Reset during START
    core_lat = 40;
    send_block();
    wait_start("rst_start_launch");
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_vals("rst_start");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    core_lat = 18;
    n0 = nout;
    send_block();
    wait_idle("rst_start_idle");
    check("rst_start_output", 64'(nout - n0), 64'd8);

    // Done held high after start drops
    core_lat = 6;
    done_hold = 10;
    p0 = pulses;
    send_block();
    send_block();
    wait_idle("hold_idle");
    check("hold_pulses", 64'(pulses - p0), 64'd2);
    check("hold_done_low_at_start", 64'(done_viol), 64'd0);
    check("hold_relaunch_gap", 64'(last_gap), 64'd2);
    done_hold = 0;

    check("model_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
